// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Definitions shared by the 9-bit serial transmitter and receiver.
//   DATA_BITS       : payload width of one frame
//   rx_state_t      : receiver FSM state encoding
//   bit_period()    : clk_divisor -> clocks per bit (0 means 256)
//   half_period()   : clocks per half bit (256 -> 128)
//   bit_reload()    : down-counter preload for one full bit period
//   half_reload()   : down-counter preload for one half bit period
// ---------------------------------------------------------------------------
package serial_pkg;

  localparam int DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  function automatic logic [8:0] bit_period(input logic [7:0] div);
    return (div == 8'd0) ? 9'd256 : {1'b0, div};
  endfunction

  function automatic logic [7:0] half_period(input logic [7:0] div);
    return (div == 8'd0) ? 8'd128 : {1'b0, div[7:1]};
  endfunction

  // The down-counter reaches zero on the cycle the event is due, so it is
  // preloaded with period-1. For div=0 this is 255, which still fits 8 bits.
  function automatic logic [7:0] bit_reload(input logic [7:0] div);
    logic [8:0] w_p;
    w_p = bit_period(div) - 9'd1;
    return w_p[7:0];
  endfunction

  function automatic logic [7:0] half_reload(input logic [7:0] div);
    return half_period(div) - 8'd1;
  endfunction

endpackage

// File: rtl/serial_rx_if.sv
// ---------------------------------------------------------------------------
// serial_rx_if
// Bundles the serial receiver line, divisor and readout signals.
//   rx          : asynchronous serial line, idle high
//   clk_divisor : clocks per bit, 0 means 256
//   rx_data     : last correctly framed word, bit 0 = first bit received
//   rx_valid    : one-cycle strobe, rx_data updated
//   frame_err   : one-cycle strobe, stop bit sampled low
//   idle        : receiver sits in IDLE
// master = line/readout side driving rx and divisor, slave = receiver.
// ---------------------------------------------------------------------------
interface serial_rx_if;
  import serial_pkg::*;

  logic                 rx;
  logic [7:0]           clk_divisor;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 idle;

  modport master (
    output rx,
    output clk_divisor,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  idle
  );

  modport slave (
    input  rx,
    input  clk_divisor,
    output rx_data,
    output rx_valid,
    output frame_err,
    output idle
  );
endinterface

// File: rtl/serial_rx_sync.sv
// ---------------------------------------------------------------------------
// serial_rx_sync
// Multi-flop synchronizer for the asynchronous rx line. The chain presets to
// 1 so the line reads idle (high) right after reset.
//   clk  : full-speed clock
//   rst  : synchronous reset, active high
//   i_d  : asynchronous input
//   o_q  : synchronized output, SYNC_STAGES cycles behind i_d
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module serial_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/serial_rx.sv
// ---------------------------------------------------------------------------
// serial_rx
// 9-bit UART-style receiver: 1 start bit (0), 9 data bits LSB first,
// 1 stop bit (1), line idle high. Bit timing follows the transmitter's
// clk_divisor convention (clocks per bit, 0 means 256).
//   clk            : full-speed clock
//   rst            : synchronous reset, active high
//   bus.rx          (in)  : asynchronous serial line
//   bus.clk_divisor (in)  : clocks per bit, latched at the start edge
//   bus.rx_data     (out) : last good word, held until the next good frame
//   bus.rx_valid    (out) : one-cycle strobe for a good frame
//   bus.frame_err   (out) : one-cycle strobe for a low stop bit
//   bus.idle        (out) : state == IDLE
// After reset the receiver sits in BREAK, so a line still held low is not
// mistaken for a start bit; it moves to IDLE once the line reads high.
// ---------------------------------------------------------------------------
module serial_rx
  import serial_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  serial_rx_if.slave  bus
);

  rx_state_t            r_state;
  logic [7:0]           r_baud;
  logic [7:0]           r_div;
  logic [3:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;

  logic                 w_rxs;
  logic                 w_tick;

  serial_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.rx),
    .o_q (w_rxs)
  );

  // The baud counter hits zero exactly on the cycle a sample is due.
  assign w_tick = (r_baud == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BREAK;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (!w_tick) begin
        r_baud <= r_baud - 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            // Latch the divisor so mid-frame changes cannot disturb timing;
            // first check lands half a bit later, in the middle of the start bit.
            r_div    <= bus.clk_divisor;
            r_baud   <= half_reload(bus.clk_divisor);
            r_bitcnt <= 4'd0;
            r_state  <= ST_START;
          end
        end

        ST_START: begin
          if (w_tick) begin
            if (w_rxs) begin
              r_state <= ST_IDLE;
            end else begin
              r_baud  <= bit_reload(r_div);
              r_state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            // LSB arrives first, so shift in from the top.
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_baud  <= bit_reload(r_div);
            if (r_bitcnt == 4'(DATA_BITS - 1)) begin
              r_state <= ST_STOP;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            // Returning to IDLE mid stop bit lets a back-to-back start
            // edge be caught as soon as it appears.
            if (w_rxs) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          if (w_rxs) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_BREAK;
        end
      endcase
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.idle      = (r_state == ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_rx
// Drives serial frames into serial_rx and compares its outputs every cycle
// against a frame-level model: the model records the synchronized line per
// cycle and, from the start-edge time T, reads the samples at T+H,
// T+H+(k+1)*D and T+H+10*D directly out of that history.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_rx;
  import serial_pkg::*;

  localparam int SYNC = 2;
  localparam int HMAX = 100000;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  serial_rx_if bus ();

  serial_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_BUSY, M_BRK} mmode_t;
  bit               hist [0:HMAX-1];
  mmode_t           m_mode = M_BRK;
  logic [SYNC-1:0]  m_sync = '1;
  int               m_T, m_D, m_H, m_off;
  bit               m_rxs;
  logic [8:0]       m_w;
  logic [8:0]       exp_data = '0;
  bit               exp_valid = 0, exp_ferr = 0, exp_idle = 0;
  bit               model_live = 0;

  // Runs on the edge that closes cycle 'cyc'; results describe cycle cyc+1.
  always @(posedge clk) begin
    m_rxs = m_sync[SYNC-1];
    if (cyc < HMAX) hist[cyc] = m_rxs;
    exp_valid = 0;
    exp_ferr  = 0;
    if (rst) begin
      m_mode     = M_BRK;
      exp_data   = '0;
      m_sync     = '1;
      model_live = 1;
    end else begin
      case (m_mode)
        M_IDLE: if (!m_rxs) begin
          m_T    = cyc;
          m_D    = (bus.clk_divisor == 8'd0) ? 256 : int'(bus.clk_divisor);
          m_H    = m_D / 2;
          m_mode = M_BUSY;
        end
        M_BUSY: begin
          m_off = cyc - m_T;
          if (m_off == m_H && m_rxs) begin
            m_mode = M_IDLE;
          end else if (m_off == m_H + 10 * m_D) begin
            m_w = '0;
            for (int k = 0; k < 9; k++) m_w[k] = hist[m_T + m_H + (k + 1) * m_D];
            if (m_rxs) begin
              exp_valid = 1;
              exp_data  = m_w;
              m_mode    = M_IDLE;
            end else begin
              exp_ferr = 1;
              m_mode   = M_BRK;
            end
          end
        end
        default: if (m_rxs) m_mode = M_IDLE;
      endcase
      m_sync = {m_sync[SYNC-2:0], bus.rx};
    end
    exp_idle = (m_mode == M_IDLE);
  end

  // ---------------- per-cycle compare + strobe log ----------------
  int         n_valid = 0, n_ferr = 0;
  int         v_cyc [$];
  logic [8:0] v_dat [$];
  int         f_cyc [$];

  always @(negedge clk) begin
    if (model_live) begin
      chk("rx_valid",  int'(bus.rx_valid),  int'(exp_valid));
      chk("frame_err", int'(bus.frame_err), int'(exp_ferr));
      chk("idle",      int'(bus.idle),      int'(exp_idle));
      chk("rx_data",   int'(bus.rx_data),   int'(exp_data));
      if (bus.rx_valid) begin
        n_valid++;
        v_cyc.push_back(cyc);
        v_dat.push_back(bus.rx_data);
      end
      if (bus.frame_err) begin
        n_ferr++;
        f_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_bit(input logic b, input int n);
    bus.rx = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input logic [8:0] w, input bit stopb, input int d,
                             input bit scramble, output int s);
    int n;
    n = (d == 0) ? 256 : d;
    bus.clk_divisor = 8'(d);
    s = cyc;
    set_bit(1'b0, n);
    // T = s+SYNC is already past, so the divisor input is free to change.
    if (scramble) bus.clk_divisor = 8'($urandom_range(4, 255));
    for (int k = 0; k < 9; k++) set_bit(w[k], n);
    set_bit(stopb, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random tests ----------------
  int s, s1, v0, f0, d, gap;
  logic [8:0] w;

  initial begin
    rst = 1'b1;
    bus.rx = 1'b1;
    bus.clk_divisor = 8'd16;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_valid",  int'(bus.rx_valid),  0);
    chk("reset frame_err", int'(bus.frame_err), 0);
    chk("reset rx_data",   int'(bus.rx_data),   0);
    chk("reset idle",      int'(bus.idle),      0);
    rst = 1'b0;
    set_bit(1'b1, 5);
    chk("idle after reset", int'(bus.idle), 1);

    // Good frame: strobe at T+H+10D+1 = T+169, T = start + SYNC.
    v0 = n_valid; f0 = n_ferr;
    drive_frame(9'h1A5, 1'b1, 16, 1'b0, s);
    set_bit(1'b1, 20);
    chk("good count", n_valid - v0, 1);
    chk("good time",  v_cyc[v0] - s, SYNC + 169);
    chk("good data",  int'(v_dat[v0]), 'h1A5);
    chk("good no ferr", n_ferr - f0, 0);

    // Back-to-back: each frame is 11 bit times, so strobes are 11*16 apart.
    v0 = n_valid;
    drive_frame(9'h000, 1'b1, 16, 1'b0, s1);
    drive_frame(9'h1FF, 1'b1, 16, 1'b0, s);
    drive_frame(9'h155, 1'b1, 16, 1'b0, s);
    set_bit(1'b1, 20);
    chk("b2b count", n_valid - v0, 3);
    chk("b2b time0", v_cyc[v0] - s1, SYNC + 169);
    chk("b2b data0", int'(v_dat[v0]), 'h000);
    chk("b2b gap1",  v_cyc[v0+1] - v_cyc[v0], 176);
    chk("b2b data1", int'(v_dat[v0+1]), 'h1FF);
    chk("b2b gap2",  v_cyc[v0+2] - v_cyc[v0+1], 176);
    chk("b2b data2", int'(v_dat[v0+2]), 'h155);

    // Framing error, long break, release.
    v0 = n_valid; f0 = n_ferr;
    drive_frame(9'h0F0, 1'b0, 16, 1'b0, s);
    set_bit(1'b0, 50 * 16);
    chk("break idle low", int'(bus.idle), 0);
    set_bit(1'b1, 40);
    chk("ferr count", n_ferr - f0, 1);
    chk("ferr time",  f_cyc[f0] - s, SYNC + 169);
    chk("ferr no valid", n_valid - v0, 0);
    chk("ferr data held", int'(bus.rx_data), 'h155);
    chk("break idle high", int'(bus.idle), 1);

    // False start, then a good frame.
    v0 = n_valid; f0 = n_ferr;
    bus.clk_divisor = 8'd16;
    set_bit(1'b0, 4);
    set_bit(1'b1, 30);
    chk("false no valid", n_valid - v0, 0);
    chk("false no ferr",  n_ferr - f0, 0);
    chk("false idle",     int'(bus.idle), 1);
    drive_frame(9'h0AA, 1'b1, 16, 1'b0, s);
    set_bit(1'b1, 20);
    chk("after false data", int'(v_dat[v0]), 'h0AA);
    chk("after false time", v_cyc[v0] - s, SYNC + 169);

    // Divisor extremes.
    v0 = n_valid;
    drive_frame(9'h101, 1'b1, 0, 1'b0, s);
    set_bit(1'b1, 20);
    chk("d256 data", int'(v_dat[v0]), 'h101);
    chk("d256 time", v_cyc[v0] - s, SYNC + 128 + 2561);
    drive_frame(9'h0FE, 1'b1, 4, 1'b0, s);
    set_bit(1'b1, 20);
    chk("d4 data", int'(v_dat[v0+1]), 'h0FE);
    chk("d4 time", v_cyc[v0+1] - s, SYNC + 2 + 41);

    // Reset during data bit 4.
    v0 = n_valid; f0 = n_ferr;
    w = 9'h0C3;
    bus.clk_divisor = 8'd16;
    set_bit(1'b0, 16);
    for (int k = 0; k < 4; k++) set_bit(w[k], 16);
    set_bit(w[4], 8);
    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst idle", int'(bus.idle), 0);
    end
    rst = 1'b0;
    set_bit(1'b1, 20);
    chk("rst release idle", int'(bus.idle), 1);
    chk("rst no valid", n_valid - v0, 0);
    chk("rst no ferr",  n_ferr - f0, 0);
    chk("rst data cleared", int'(bus.rx_data), 0);
    drive_frame(9'h13C, 1'b1, 16, 1'b0, s);
    set_bit(1'b1, 20);
    chk("post rst data", int'(v_dat[v0]), 'h13C);

    // Randomized frames; divisor scrambled mid-frame, random gaps and errors.
    for (int i = 0; i < 32; i++) begin
      d = (i == 7 || i == 21) ? 0 : int'($urandom_range(4, 24));
      w = 9'($urandom);
      drive_frame(w, ($urandom % 6) != 0, d, 1'b1, s);
      gap = int'($urandom_range(0, 10));
      if (gap == 0 && bus.rx == 1'b0) gap = 1;
      set_bit(1'b1, gap);
    end
    set_bit(1'b1, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
